btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth per button; the legal range is 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 270000, sets the consecutive stable samples required before a level is accepted (10 ms at 27 MHz); the legal minimum is 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Ports btn1_raw and btn2_raw, input, 1 bit each: asynchronous, bouncing, active-low push-button pins.
REQ-006 Ports btn1 and btn2, output, 1 bit each: debounced level with the same active-low polarity; they are drop-in sources for the NAND/LED stage inputs.
REQ-007 Ports btn1_press and btn2_press, output, 1 bit each: one-cycle pulse when the debounced level goes 1->0.
REQ-008 Ports btn1_release and btn2_release, output, 1 bit each: one-cycle pulse when the debounced level goes 0->1.

Function
REQ-009 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain before any other logic uses it.
REQ-010 Each channel SHALL run an independent FSM with four states.
- RELEASED: output 1.
- CONFIRM_PRESS: output 1.
- PRESSED: output 0.
- CONFIRM_RELEASE: output 0.
REQ-011 In RELEASED, a synchronized 0 SHALL move the channel to CONFIRM_PRESS with the counter loaded to 1.
REQ-012 In PRESSED, a synchronized 1 SHALL move the channel to CONFIRM_RELEASE with the counter loaded to 1.
REQ-013 In a CONFIRM state, a matching sample SHALL increment the counter.
- When a matching sample arrives with counter = DEBOUNCE_CYCLES-1, the FSM SHALL move to the target stable state on that edge.
- On that same edge, the debounced output SHALL toggle and the counter SHALL clear.
REQ-014 In a CONFIRM state, any non-matching sample SHALL return the FSM to the previous stable state and clear the counter.
- No pulse and no output change SHALL occur.
REQ-015 Latency: a raw edge held clean SHALL appear on the debounced output exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
REQ-016 The press and release pulses SHALL be registered.
- Each pulse SHALL assert in the same cycle the debounced output changes, for exactly one cycle.
- A press pulse and a release pulse SHALL never assert together on one channel.
REQ-017 The counter width SHALL be clog2(DEBOUNCE_CYCLES).
- The counter SHALL never exceed DEBOUNCE_CYCLES-1.
- The counter SHALL never wrap.
REQ-018 The two channels SHALL share no state.
- Simultaneous activity on both buttons SHALL produce independent, possibly coincident, pulses.

Reset
REQ-019 While rst=1, every channel SHALL hold the following values.
- Synchronizer flops: 1.
- FSM state: RELEASED.
- Counter: 0.
- btn1 and btn2: 1.
- All press and release pulses: 0.
REQ-020 Asserting rst mid-confirmation SHALL abandon the confirmation with no pulse.
- After rst deasserts, a held button SHALL require the full REQ-015 latency again.

Structure
REQ-021 A shared package/include SHALL hold the FSM state encodings (2-bit) and the default values of SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-022 One sub-module, debounce_channel, SHALL implement the synchronizer, FSM, counter and pulses for one button.
- btn_debounce SHALL instantiate debounce_channel twice.

Verification (run with SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-023 Hold btn1_raw=0 through reset, then deassert rst at cycle 0.
- Required: btn1 is 1 until cycle 6, then 0.
- Required: btn1_press is high only in cycle 6.
- Required: btn2 stays 1.
REQ-024 Drive btn1_raw as 0 for 3 cycles, then 1 for 1 cycle, then 0 steadily.
- Required: no press pulse from the first burst.
- Required: btn1 falls exactly 6 cycles after the steady 0 begins.
REQ-025 From PRESSED, release btn1_raw to 1 cleanly.
- Required: btn1 rises 6 cycles later with exactly one btn1_release pulse.
- Required: a 1-cycle glitch to 1 while pressed produces no release pulse.
REQ-026 Press btn1_raw and btn2_raw on the same edge.
- Required: btn1_press and btn2_press pulse in the same cycle.
- Required: btn1 and btn2 fall together.
REQ-027 Assert rst for 1 cycle when the counter is 3 during CONFIRM_PRESS.
- Required: no press pulse and btn1 stays 1.
- Required: with the button still held, btn1 falls 6 cycles after rst deasserts.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer.
//   db_state_t          : 2-bit per-channel FSM state encoding
//   DEF_SYNC_STAGES     : default synchronizer depth
//   DEF_DEBOUNCE_CYCLES : default stable-sample count (10 ms at 27 MHz)
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED        = 2'b00,
    ST_CONFIRM_PRESS   = 2'b01,
    ST_PRESSED         = 2'b10,
    ST_CONFIRM_RELEASE = 2'b11
  } db_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 270000;

endpackage

// File: rtl/btn_debounce_channel.sv
// One debounced push-button channel: synchronizer, confirm FSM, stable-sample
// counter and registered press/release pulses.
// Ports:
//   clk           : clock, all state on rising edge
//   rst           : synchronous active-high reset
//   raw           : asynchronous active-low button pin
//   level         : debounced level, active-low
//   press_pulse   : one-cycle pulse when level goes 1->0
//   release_pulse : one-cycle pulse when level goes 0->1
module debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sample;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d, press_d, release_d;

  // Synchronizer: resets to the idle (released) level so no false press is
  // seen while the chain refills after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= '1;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
    end
  end

  assign sample = sync_p[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a confirm state counts matching samples; the sample that
  // arrives with the counter at its last value completes the confirmation,
  // any mismatch falls back to the previous stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RELEASED: begin
        if (!sample) begin
          state_d = ST_CONFIRM_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CONFIRM_PRESS: begin
        if (sample) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (sample) begin
          state_d = ST_CONFIRM_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CONFIRM_RELEASE: begin
        if (!sample) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered level and the
  // pulses change on the same edge as the state transition.
  always_comb begin
    level_d   = (state_d == ST_RELEASED) || (state_d == ST_CONFIRM_PRESS);
    press_d   = (state_q == ST_CONFIRM_PRESS)   && (state_d == ST_PRESSED);
    release_d = (state_q == ST_CONFIRM_RELEASE) && (state_d == ST_RELEASED);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      level         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Two-button debouncer: two fully independent debounce_channel instances.
// Ports:
//   clk, rst                   : clock and synchronous active-high reset
//   btn1_raw, btn2_raw         : asynchronous bouncing active-low pins
//   btn1, btn2                 : debounced active-low levels
//   btn1_press, btn2_press     : one-cycle pulse on debounced 1->0
//   btn1_release, btn2_release : one-cycle pulse on debounced 0->1
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic btn1,
  output logic btn2,
  output logic btn1_press,
  output logic btn2_press,
  output logic btn1_release,
  output logic btn2_release
);

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk          (clk),
    .rst          (rst),
    .raw          (btn1_raw),
    .level        (btn1),
    .press_pulse  (btn1_press),
    .release_pulse(btn1_release)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch2 (
    .clk          (clk),
    .rst          (rst),
    .raw          (btn2_raw),
    .level        (btn2),
    .press_pulse  (btn2_press),
    .release_pulse(btn2_release)
  );

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Reference model: each channel delays its raw input by S samples, then counts
// the run of consecutive samples that differ from the current debounced level;
// a run of D flips the level and emits the matching pulse.
module tb_btn_debounce;

  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn1_raw = 1'b1;
  logic btn2_raw = 1'b1;
  logic btn1, btn2, btn1_press, btn2_press, btn1_release, btn2_release;

  int errors = 0;
  int checks = 0;

  // model state, index 0 = button 1, index 1 = button 2
  bit pipe [2][S];
  bit lvl  [2];
  int run  [2];
  bit ep   [2];
  bit er   [2];

  btn_debounce #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn1_raw    (btn1_raw),
    .btn2_raw    (btn2_raw),
    .btn1        (btn1),
    .btn2        (btn2),
    .btn1_press  (btn1_press),
    .btn2_press  (btn2_press),
    .btn1_release(btn1_release),
    .btn2_release(btn2_release)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int i = 0; i < S; i++) pipe[ch][i] = 1'b1;
      lvl[ch] = 1'b1;
      run[ch] = 0;
      ep[ch]  = 1'b0;
      er[ch]  = 1'b0;
    end
  endfunction

  function automatic void model_edge(bit r, bit raw0, bit raw1);
    bit s;
    bit rw;
    if (r) begin
      model_reset();
      return;
    end
    for (int ch = 0; ch < 2; ch++) begin
      rw = (ch == 0) ? raw0 : raw1;
      ep[ch] = 1'b0;
      er[ch] = 1'b0;
      s = pipe[ch][S-1];
      for (int i = S-1; i > 0; i--) pipe[ch][i] = pipe[ch][i-1];
      pipe[ch][0] = rw;
      if (s != lvl[ch]) run[ch]++;
      else run[ch] = 0;
      if (run[ch] == D) begin
        lvl[ch] = s;
        run[ch] = 0;
        if (s == 1'b0) ep[ch] = 1'b1;
        else er[ch] = 1'b1;
      end
    end
  endfunction

  function automatic logic [5:0] exp_vec();
    return {lvl[0], lvl[1], ep[0], ep[1], er[0], er[1]};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {btn1, btn2, btn1_press, btn2_press, btn1_release, btn2_release};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge(rst, btn1_raw, btn2_raw);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn1_raw = 1'b0;
    btn2_raw = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (dut_vec() !== 6'b110000) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%b want=110000", c, dut_vec());
      end
    end
  endtask

  // btn1_raw held low through reset; rst drops in cycle 0
  task automatic test_hold_through_reset();
    logic want_b1, want_p1;
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      want_b1 = (c < 6);
      want_p1 = (c == 6);
      checks++;
      if (btn1 !== want_b1 || btn1_press !== want_p1 || btn2 !== 1'b1) begin
        errors++;
        $display("FAIL hold_reset cyc=%0d got btn1=%b press=%b btn2=%b want %b %b 1",
                 c, btn1, btn1_press, btn2, want_b1, want_p1);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hold_reset_model cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
    btn1_raw = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hold_reset_release cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_burst();
    int fall = -1;
    int pcyc = -1;
    int npress = 0;
    btn1_raw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) btn1_raw = 1'b1;
      cyc();
      checks++;
      if (btn1_press !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL burst_short cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
    btn1_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (btn1_press) begin
        npress++;
        pcyc = k;
      end
      if (fall < 0 && btn1 === 1'b0) fall = k;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL burst_model cyc=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (fall !== 6 || pcyc !== 6 || npress !== 1) begin
      errors++;
      $display("FAIL burst_latency got fall=%0d press_at=%0d presses=%0d want 6 6 1",
               fall, pcyc, npress);
    end
  endtask

  task automatic test_glitch_and_release();
    int rise = -1;
    int nrel = 0;
    int rcyc = -1;
    btn1_raw = 1'b1;
    cyc();
    btn1_raw = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      checks++;
      if (btn1 !== 1'b0 || btn1_release !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
    btn1_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (btn1_release) begin
        nrel++;
        rcyc = k;
      end
      if (rise < 0 && btn1 === 1'b1) rise = k;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL release_model cyc=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (rise !== 6 || rcyc !== 6 || nrel !== 1) begin
      errors++;
      $display("FAIL release_latency got rise=%0d rel_at=%0d releases=%0d want 6 6 1",
               rise, rcyc, nrel);
    end
  endtask

  task automatic test_simultaneous();
    int f1 = -1, f2 = -1, p1 = -1, p2 = -1;
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (btn1_press) p1 = k;
      if (btn2_press) p2 = k;
      if (f1 < 0 && btn1 === 1'b0) f1 = k;
      if (f2 < 0 && btn2 === 1'b0) f2 = k;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simul_model cyc=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (f1 !== 6 || f2 !== 6 || p1 !== 6 || p2 !== 6) begin
      errors++;
      $display("FAIL simul_press got fall=%0d,%0d press=%0d,%0d want all 6", f1, f2, p1, p2);
    end
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simul_release cyc=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  // rst pulsed when the confirm counter has reached 3
  task automatic test_reset_mid_confirm();
    int fall = -1;
    int npress = 0;
    int pcyc = -1;
    btn1_raw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks++;
      if (btn1 !== 1'b1 || btn1_press !== 1'b0) begin
        errors++;
        $display("FAIL midrst_pre cyc=%0d got btn1=%b press=%b want 1 0", c, btn1, btn1_press);
      end
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (btn1 !== 1'b1 || btn1_press !== 1'b0) begin
      errors++;
      $display("FAIL midrst_during got btn1=%b press=%b want 1 0", btn1, btn1_press);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (btn1_press) begin
        npress++;
        pcyc = k;
      end
      if (fall < 0 && btn1 === 1'b0) fall = k;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_model cyc=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (fall !== 6 || pcyc !== 6 || npress !== 1) begin
      errors++;
      $display("FAIL midrst_latency got fall=%0d press_at=%0d presses=%0d want 6 6 1",
               fall, pcyc, npress);
    end
    btn1_raw = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
  endtask

  task automatic test_random();
    int hold1 = 0, hold2 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold1 == 0) begin
        btn1_raw = 1'($urandom_range(0, 1));
        hold1 = $urandom_range(1, 8);
      end
      if (hold2 == 0) begin
        btn2_raw = 1'($urandom_range(0, 1));
        hold2 = $urandom_range(1, 8);
      end
      hold1--;
      hold2--;
      rst = ($urandom_range(0, 199) == 0);
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
      checks++;
      if ((btn1_press && btn1_release) || (btn2_press && btn2_release)) begin
        errors++;
        $display("FAIL random_excl cyc=%0d got=%b want no press+release together",
                 c, dut_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold_through_reset();
    test_burst();
    test_glitch_and_release();
    test_simultaneous();
    test_reset_mid_confirm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
